// File: rtl/bp_cfg_tile_enumerator.sv
// Configuration tile enumerator: after a start pulse, writes each core tile's
// HARTID (y*cc_x_dim_p + x), then clears FREEZE on every tile, X fastest.
// Each write is a valid/ready transfer with a stable, registered payload.
module bp_cfg_tile_enumerator #(
  parameter int unsigned cc_x_dim_p       = 1,
  parameter int unsigned cc_y_dim_p       = 1,
  parameter int unsigned x_cord_width_p   = 4,
  parameter int unsigned y_cord_width_p   = 4,
  parameter int unsigned cfg_data_width_p = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [x_cord_width_p-1:0]   cfg_x_o,
  output logic [y_cord_width_p-1:0]   cfg_y_o,
  output logic [1:0]                  cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned XW = x_cord_width_p;
  localparam int unsigned YW = y_cord_width_p;
  localparam int unsigned DW = cfg_data_width_p;

  localparam logic [1:0] ADDR_FREEZE = 2'd0;
  localparam logic [1:0] ADDR_HARTID = 2'd1;

  localparam logic [XW-1:0] X_LAST  = XW'(cc_x_dim_p - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(cc_y_dim_p - 1);
  localparam logic [DW-1:0] X_DIM_D = DW'(cc_x_dim_p);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HARTID   = 2'd1,
    ST_UNFREEZE = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // State and tile counters; counters sit at 0 whenever no write is pending
  state_e          r_state;
  logic [XW-1:0]   r_x;
  logic [YW-1:0]   r_y;

  // Registered outputs
  logic            r_cfg_v;
  logic [1:0]      r_cfg_addr;
  logic [DW-1:0]   r_cfg_data;
  logic            r_busy;
  logic            r_done;

  state_e          w_state_nxt;
  logic [XW-1:0]   w_x_nxt;
  logic [YW-1:0]   w_y_nxt;
  logic            w_xfer;
  logic            w_x_last;
  logic            w_tile_last;

  logic            w_cfg_v_nxt;
  logic [1:0]      w_cfg_addr_nxt;
  logic [DW-1:0]   w_cfg_data_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic [DW-1:0]   w_hartid_nxt;

  assign w_xfer      = r_cfg_v & cfg_ready_i;
  assign w_x_last    = (r_x == X_LAST);
  assign w_tile_last = w_x_last & (r_y == Y_LAST);

  // State and counter register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
    end
  end

  // Next state and counter advance; counters only move on an accepted write
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = ST_HARTID;
        end
      end
      ST_HARTID, ST_UNFREEZE: begin
        if (w_xfer) begin
          if (w_tile_last) begin
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_state_nxt = (r_state == ST_HARTID) ? ST_UNFREEZE : ST_DONE;
          end else if (w_x_last) begin
            w_x_nxt = '0;
            w_y_nxt = r_y + YW'(1);
          end else begin
            w_x_nxt = r_x + XW'(1);
          end
        end
      end
      ST_DONE: begin
        if (start_i) begin
          w_state_nxt = ST_HARTID;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Hart id of the tile addressed in the next cycle
  assign w_hartid_nxt = (DW'(w_y_nxt) * X_DIM_D) + DW'(w_x_nxt);

  // Output values for the next cycle, decoded from the next state
  always_comb begin
    w_cfg_v_nxt    = 1'b0;
    w_cfg_addr_nxt = ADDR_FREEZE;
    w_cfg_data_nxt = '0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (w_state_nxt)
      ST_HARTID: begin
        w_cfg_v_nxt    = 1'b1;
        w_busy_nxt     = 1'b1;
        w_cfg_addr_nxt = ADDR_HARTID;
        w_cfg_data_nxt = w_hartid_nxt;
      end
      ST_UNFREEZE: begin
        w_cfg_v_nxt    = 1'b1;
        w_busy_nxt     = 1'b1;
        w_cfg_addr_nxt = ADDR_FREEZE;
        w_cfg_data_nxt = '0;
      end
      ST_DONE: begin
        w_done_nxt = 1'b1;
      end
      default: begin
        w_cfg_v_nxt = 1'b0;
      end
    endcase
  end

  // Output register; payload is held while a write is stalled
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cfg_v    <= 1'b0;
      r_cfg_addr <= '0;
      r_cfg_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cfg_v    <= w_cfg_v_nxt;
      r_cfg_addr <= w_cfg_addr_nxt;
      r_cfg_data <= w_cfg_data_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign cfg_v_o    = r_cfg_v;
  assign cfg_x_o    = r_x;
  assign cfg_y_o    = r_y;
  assign cfg_addr_o = r_cfg_addr;
  assign cfg_data_o = r_cfg_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_bp_cfg_tile_enumerator.sv
// Scoreboard bench: dut0 is a 1x1 enumerator, dut1 a 2x2 one. Expected writes
// are queued at each start; a negedge monitor pops and compares every transfer.
module tb_bp_cfg_tile_enumerator;

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned PW = XW + YW + 2 + DW;

  typedef logic [PW-1:0] pay_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start [2];
  logic          ready [2];
  logic          v     [2];
  logic          busy  [2];
  logic          done  [2];
  logic [XW-1:0] x     [2];
  logic [YW-1:0] y     [2];
  logic [1:0]    addr  [2];
  logic [DW-1:0] data  [2];

  bit            rnd_mode [2];
  pay_t          q0 [$];
  pay_t          q1 [$];
  int            dim_x [2] = '{1, 2};
  int            dim_y [2] = '{1, 2};

  int            n_pass = 0;
  int            n_total = 0;
  int            timeouts = 0;
  int            timeouts_seen = 0;

  always #5 clk = ~clk;

  bp_cfg_tile_enumerator u_dut0 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[0]),
    .cfg_v_o(v[0]), .cfg_ready_i(ready[0]),
    .cfg_x_o(x[0]), .cfg_y_o(y[0]), .cfg_addr_o(addr[0]), .cfg_data_o(data[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );

  bp_cfg_tile_enumerator #(.cc_x_dim_p(2), .cc_y_dim_p(2)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[1]),
    .cfg_v_o(v[1]), .cfg_ready_i(ready[1]),
    .cfg_x_o(x[1]), .cfg_y_o(y[1]), .cfg_addr_o(addr[1]), .cfg_data_o(data[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Reference: HARTID pass then FREEZE-clear pass, X fastest, over the whole grid
  function automatic void push_seq(input int d);
    pay_t e;
    for (int ph = 0; ph < 2; ph++) begin
      for (int yy = 0; yy < dim_y[d]; yy++) begin
        for (int xx = 0; xx < dim_x[d]; xx++) begin
          if (ph == 0) e = {XW'(xx), YW'(yy), 2'd1, DW'(yy * dim_x[d] + xx)};
          else         e = {XW'(xx), YW'(yy), 2'd0, DW'(0)};
          if (d == 0) q0.push_back(e);
          else        q1.push_back(e);
        end
      end
    end
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, d, act, exp, $time);
  endtask

  // Monitor-side model of busy/done, plus stall bookkeeping
  bit   exp_busy   [2];
  bit   exp_done   [2];
  bit   prev_stall [2];
  pay_t prev_pay   [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      pay_t got;
      pay_t e;
      bit   popped_last;
      got = {x[d], y[d], addr[d], data[d]};
      popped_last = 1'b0;
      if (!rst_n) begin
        chk("reset_outputs", d, 32'({v[d], busy[d], done[d], got}), 32'd0);
        if (d == 0) q0.delete();
        else        q1.delete();
        exp_busy[d]   = 1'b0;
        exp_done[d]   = 1'b0;
        prev_stall[d] = 1'b0;
      end else begin
        chk("cfg_v", d, 32'(v[d]), 32'(exp_busy[d]));
        chk("busy", d, 32'(busy[d]), 32'(exp_busy[d]));
        chk("done", d, 32'(done[d]), 32'(exp_done[d]));
        if (!v[d]) chk("idle_payload", d, 32'(got), 32'd0);
        if (prev_stall[d]) chk("stall_hold", d, 32'({v[d], got}), 32'({1'b1, prev_pay[d]}));
        if (v[d] && ready[d]) begin
          if (qsize(d) == 0) begin
            n_total++;
            $display("FAIL extra_transfer dut%0d: got payload 0x%0h, expected no transfer (t=%0t)",
                     d, got, $time);
          end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("transfer", d, 32'(got), 32'(e));
            popped_last = (qsize(d) == 0);
          end
        end
        prev_stall[d] = v[d] && !ready[d];
        prev_pay[d]   = got;
        if (start[d] && !exp_busy[d]) begin
          exp_busy[d] = 1'b1;
          exp_done[d] = 1'b0;
        end else if (popped_last) begin
          exp_busy[d] = 1'b0;
          exp_done[d] = 1'b1;
        end
      end
    end
    if (timeouts != timeouts_seen) begin
      chk("wait_timeout", 0, 32'(timeouts), 32'(timeouts_seen));
      timeouts_seen = timeouts;
    end
  end

  // Ready driver: held high, or a random stall pattern per dut
  initial begin
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) ready[d] = rnd_mode[d] ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic pulse(input int d);
    @(posedge clk);
    #1 start[d] = 1'b1;
    @(posedge clk);
    #1 start[d] = 1'b0;
  endtask

  task automatic wait_empty(input int d, input int budget);
    int n;
    n = 0;
    while (qsize(d) != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (qsize(d) != 0) timeouts++;
    repeat (3) @(posedge clk);
  endtask

  task automatic run(input int d);
    push_seq(d);
    pulse(d);
    wait_empty(d, 200);
  endtask

  initial begin
    rst_n       = 1'b0;
    start[0]    = 1'b0;
    start[1]    = 1'b0;
    rnd_mode[0] = 1'b0;
    rnd_mode[1] = 1'b0;
    repeat (3) @(posedge clk);

    // start in the first edge after reset release
    #1;
    push_seq(1);
    rst_n    = 1'b1;
    start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_empty(1, 100);

    // 1x1 grid, ready held high
    run(0);

    // 2x2 grid under random stalls
    rnd_mode[1] = 1'b1;
    repeat (3) run(1);
    rnd_mode[1] = 1'b0;

    // start during the third HARTID write is ignored
    push_seq(1);
    pulse(1);
    repeat (2) @(posedge clk);
    #1 start[1] = 1'b1;
    @(posedge clk);
    #1 start[1] = 1'b0;
    wait_empty(1, 100);

    // start while done restarts from (0,0)
    run(1);

    // reset mid-UNFREEZE, off the clock edge
    push_seq(1);
    pulse(1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rnd_mode[1] = 1'b1;
    repeat (8) @(posedge clk);
    rnd_mode[1] = 1'b0;
    run(1);
    run(0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_cfg_tile_enumerator.md
BP_CFG_TILE_ENUMERATOR -- requirements
Module: bp_cfg_tile_enumerator

Interface
REQ-001 The block SHALL have the following parameters:
- cc_x_dim_p, default 1: number of core tiles in X; range 1..2^x_cord_width_p.
- cc_y_dim_p, default 1: number of core tiles in Y; range 1..2^y_cord_width_p.
- x_cord_width_p, default 4: width of the X coordinate.
- y_cord_width_p, default 4: width of the Y coordinate.
- cfg_data_width_p, default 8: width of configuration write data; 2^cfg_data_width_p SHALL be at least cc_x_dim_p*cc_y_dim_p.
REQ-002 The block SHALL have the following ports:
- clk_i  in  1  sole clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle request to begin enumeration.
- cfg_v_o  out  1  configuration write valid.
- cfg_ready_i  in  1  downstream ready to accept the write.
- cfg_x_o  out  x_cord_width_p  target tile X coordinate.
- cfg_y_o  out  y_cord_width_p  target tile Y coordinate.
- cfg_addr_o  out  2  register address: 0 = FREEZE, 1 = HARTID.
- cfg_data_o  out  cfg_data_width_p  write data.
- busy_o  out  1  enumeration in progress.
- done_o  out  1  enumeration complete.

Function
REQ-003 The FSM SHALL have four states: IDLE, HARTID, UNFREEZE, DONE.
REQ-004 IDLE->HARTID SHALL occur when start_i=1 at a clock edge; cfg_v_o SHALL rise in the following cycle, giving 1-cycle latency.
REQ-005 HARTID SHALL issue one write per tile, addr=1, data=y*cc_x_dim_p+x, zero-extended; X SHALL iterate fastest from (0,0) to (cc_x_dim_p-1, cc_y_dim_p-1).
REQ-006 After the HARTID write to the last tile is accepted, the FSM SHALL enter UNFREEZE and issue one write per tile, same order, addr=0, data=0.
REQ-007 After the UNFREEZE write to the last tile is accepted, the FSM SHALL enter DONE; done_o SHALL be 1 in the next cycle, and busy_o and cfg_v_o SHALL be 0.
REQ-008 A transfer SHALL occur only on a cycle with cfg_v_o=1 and cfg_ready_i=1; the X/Y counters SHALL advance only on a transfer.
REQ-009 Once cfg_v_o=1, cfg_x_o, cfg_y_o, cfg_addr_o and cfg_data_o SHALL hold stable until the transfer, and cfg_v_o SHALL NOT drop before the transfer.
REQ-010 Back-to-back transfers SHALL be supported: with cfg_ready_i held at 1, one transfer per cycle, with no bubbles between HARTID and UNFREEZE.
REQ-011 The X counter SHALL wrap to 0 and the Y counter SHALL increment when X=cc_x_dim_p-1 is transferred; both SHALL wrap to 0 on the phase change.
REQ-012 busy_o SHALL be 1 exactly in HARTID and UNFREEZE.
REQ-013 start_i while in HARTID or UNFREEZE SHALL be ignored.
REQ-014 start_i in DONE SHALL clear done_o and restart at HARTID (0,0) with the same 1-cycle latency.
REQ-015 cfg_ready_i while cfg_v_o=0 SHALL have no effect.
REQ-016 When cfg_v_o=0, cfg_x_o, cfg_y_o, cfg_addr_o and cfg_data_o SHALL be 0.
REQ-017 A total of exactly 2*cc_x_dim_p*cc_y_dim_p transfers SHALL occur per enumeration.
REQ-018 All outputs SHALL be driven from registers.

Reset
REQ-019 While reset_n_i=0, the state SHALL be IDLE and all outputs SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-020 Reset asserted mid-enumeration SHALL abort immediately, with no further transfers; after release the block SHALL wait in IDLE for start_i.
REQ-021 start_i in the first edge after reset release SHALL be honoured.

Verification
REQ-022 Default 1x1, ready=1, start pulse -> exactly two transfers: (0,0,addr1,data0), then (0,0,addr0,data0); done_o=1 one cycle after the second.
REQ-023 cc_x_dim_p=2, cc_y_dim_p=2, ready=1 -> HARTID data 0,1,2,3 at (0,0),(1,0),(0,1),(1,1); then four FREEZE writes in the same order; 8 consecutive cycles of cfg_v_o=1.
REQ-024 Random cfg_ready_i stall pattern on 2x2 -> payload stable during every stall; same 8-transfer sequence as REQ-023; no duplicates or skips.
REQ-025 start_i pulsed during the third HARTID transfer -> ignored; sequence unchanged. start_i in DONE -> done_o falls and the sequence repeats from (0,0).
REQ-026 reset_n_i pulled low mid-UNFREEZE, off a clock edge -> cfg_v_o, busy_o and done_o are 0 immediately; after release, no transfers until start_i, then the full sequence from (0,0).
